frame_scheduler: RTL

- Controller that sequences the pixel-array phase sequencer (erase/corr/expose/convert/read) frame by frame.
- Holds host configuration in pending/active (shadow) registers and issues one-cycle frame-start pulses at a programmed frame period.
- Tracks datapath completion, counts frames and flags period overruns.
- Sits between the host/config bus and the sensor datapath.

---
 rtl/frame_scheduler.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
//
// Frame-level controller for the pixel-array phase sequencer. The host writes
// exposure / period / frame-target into pending registers at any time; every
// entry into LAUNCH copies them into the active (shadow) set, so a frame in
// flight never sees a configuration change. Launches are spaced by the
// programmed period, completions from the datapath are counted, and a sticky
// overrun flag records frames whose datapath work outlasted the period.
//
// Optional feature macro: FRAME_TIMEOUT_EN
//   When defined, adds o_timeout (sticky) and a watchdog that aborts a frame
//   left in RUN for TIMEOUT cycles after its launch. TIMEOUT must fit in PER_W.
//
// Ports
//   i_clk           clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_cfg_we        load pending config this cycle
//   i_cfg_exposure  exposure length forwarded to the datapath
//   i_cfg_period    launch-to-launch spacing in cycles (0 behaves as 1)
//   i_cfg_frames    frames per run, 0 = continuous
//   i_start         begin a run (honoured only in IDLE, and not with i_stop)
//   i_stop          finish the current frame, then go IDLE
//   i_clr_status    clear overrun (and timeout)
//   i_dp_done       one-cycle pulse: datapath finished a frame
//   o_dp_start      one-cycle launch pulse (registered, glitch-free)
//   o_dp_exposure   active exposure, stable for the whole frame
//   o_busy          state is not IDLE
//   o_frame_done    one-cycle pulse per accepted i_dp_done
//   o_frame_count   completed frames in this run, wraps
//   o_overrun       sticky: period elapsed before i_dp_done
//   o_timeout       (FRAME_TIMEOUT_EN only) sticky watchdog flag
//   o_dbg_state     current FSM state encoding
//
// Handshake: i_dp_done is a single-cycle event with no back-pressure; it is
// accepted only in RUN, and pulses in any other state are dropped.
// -----------------------------------------------------------------------------
module frame_scheduler #(
    parameter int EXP_W   = 8,
    parameter int PER_W   = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cfg_we,
    input  logic [EXP_W-1:0] i_cfg_exposure,
    input  logic [PER_W-1:0] i_cfg_period,
    input  logic [CNT_W-1:0] i_cfg_frames,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_clr_status,
    input  logic             i_dp_done,
    output logic             o_dp_start,
    output logic [EXP_W-1:0] o_dp_exposure,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic [CNT_W-1:0] o_frame_count,
    output logic             o_overrun,
`ifdef FRAME_TIMEOUT_EN
    output logic             o_timeout,
`endif
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_RUN     = 2'd2,
        S_HOLDOFF = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [EXP_W-1:0] r_pend_exposure, r_act_exposure;
    logic [PER_W-1:0] r_pend_period,   r_act_period;
    logic [CNT_W-1:0] r_pend_frames,   r_act_frames;

    logic [PER_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_frame_count;
    logic             r_stop_pending;
    logic             r_dp_start;
    logic             r_frame_done;
    logic             r_overrun;

    logic [PER_W-1:0] w_per_m1;
    logic             w_period_up;
    logic             w_stop_eff;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_last_frame;
    logic             w_done_acc;
    logic             w_ovr_set;
    logic             w_run_start;
    logic             w_to_hit;

    // Period 0 is treated as 1, so the threshold bottoms out at 0.
    assign w_per_m1     = (r_act_period == '0) ? '0 : r_act_period - PER_W'(1);
    assign w_period_up  = (r_cnt >= w_per_m1);
    // A stop arriving this cycle already blocks the next launch.
    assign w_stop_eff   = r_stop_pending | i_stop;
    assign w_count_inc  = r_frame_count + CNT_W'(1);
    assign w_last_frame = (r_act_frames != '0) && (w_count_inc == r_act_frames);
    assign w_done_acc   = (r_state == S_RUN) && i_dp_done;
    assign w_ovr_set    = (r_state == S_RUN) && !i_dp_done && w_period_up;
    assign w_run_start  = (r_state == S_IDLE) && (w_next == S_LAUNCH);

`ifdef FRAME_TIMEOUT_EN
    // r_cnt counts cycles since LAUNCH (LAUNCH cycle = 0), so the watchdog
    // fires on the cycle whose end marks TIMEOUT elapsed cycles.
    localparam logic [PER_W-1:0] TO_LIM = PER_W'(TIMEOUT - 1);
    logic r_timeout;
    assign w_to_hit  = (r_state == S_RUN) && !i_dp_done && (r_cnt >= TO_LIM);
    assign o_timeout = r_timeout;
`else
    assign w_to_hit  = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start && !i_stop) w_next = S_LAUNCH;
            S_LAUNCH:  w_next = S_RUN;
            S_RUN: begin
                if (i_dp_done) begin
                    if (w_stop_eff || w_last_frame) w_next = S_IDLE;
                    else if (w_period_up)           w_next = S_LAUNCH;
                    else                            w_next = S_HOLDOFF;
                end else if (w_to_hit) begin
                    w_next = S_IDLE;
                end
            end
            S_HOLDOFF: begin
                if (w_stop_eff)       w_next = S_IDLE;
                else if (w_period_up) w_next = S_LAUNCH;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= S_IDLE;
            r_pend_exposure <= '0;
            r_pend_period   <= '0;
            r_pend_frames   <= '0;
            r_act_exposure  <= '0;
            r_act_period    <= '0;
            r_act_frames    <= '0;
            r_cnt           <= '0;
            r_frame_count   <= '0;
            r_stop_pending  <= 1'b0;
            r_dp_start      <= 1'b0;
            r_frame_done    <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_dp_start   <= (w_next == S_LAUNCH);
            r_frame_done <= w_done_acc;

            if (i_cfg_we) begin
                r_pend_exposure <= i_cfg_exposure;
                r_pend_period   <= i_cfg_period;
                r_pend_frames   <= i_cfg_frames;
            end

            // Shadow copy takes the pending value from before this edge, so a
            // write landing on the same edge is held for the following frame.
            if (w_next == S_LAUNCH) begin
                r_act_exposure <= r_pend_exposure;
                r_act_period   <= r_pend_period;
                r_act_frames   <= r_pend_frames;
                r_cnt          <= '0;
            end else if (r_state != S_IDLE && r_cnt != '1) begin
                r_cnt <= r_cnt + PER_W'(1);
            end

            if (w_run_start)     r_frame_count <= '0;
            else if (w_done_acc) r_frame_count <= w_count_inc;

            if (w_run_start)                      r_stop_pending <= 1'b0;
            else if (r_state != S_IDLE && i_stop) r_stop_pending <= 1'b1;

            // Set beats clear when both happen together.
            if (w_ovr_set)         r_overrun <= 1'b1;
            else if (i_clr_status) r_overrun <= 1'b0;
        end
    end

`ifdef FRAME_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)          r_timeout <= 1'b0;
        else if (w_to_hit)     r_timeout <= 1'b1;
        else if (i_clr_status) r_timeout <= 1'b0;
    end
`endif

    assign o_dp_start    = r_dp_start;
    assign o_dp_exposure = r_act_exposure;
    assign o_busy        = (r_state != S_IDLE);
    assign o_frame_done  = r_frame_done;
    assign o_frame_count = r_frame_count;
    assign o_overrun     = r_overrun;
    assign o_dbg_state   = r_state;

endmodule
